// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N:1 mux slice.
// Provides mode encodings and the modulo-N index increment.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned idx_wrap(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_n_rr_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// Ports: mode, select, inp, in_valid/in_ready, out, out_valid/out_ready, out_sel.
interface mux_n_rr_if #(
  parameter int N = 16,
  parameter int W = 8,
  parameter int M = $clog2(N)
);

  logic           mode;
  logic [M-1:0]   select;
  logic [N*W-1:0] inp;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_sel;

  modport master (
    output mode, select, inp, in_valid, out_ready,
    input  in_ready, out, out_valid, out_sel
  );

  modport slave (
    input  mode, select, inp, in_valid, out_ready,
    output in_ready, out, out_valid, out_sel
  );

endinterface

// File: rtl/rr_arbiter_n.sv
// Rotating-priority arbiter: searches ptr+1, ptr+2, ... modulo N.
// Ports: clk, rst, req[N], advance in; grant_idx[M], grant_valid out.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int N = 16,
  parameter int M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [M-1:0] grant_idx,
  output logic         grant_valid
);

  logic [M-1:0] ptr;

  always_comb begin
    int unsigned c;
    grant_idx   = '0;
    grant_valid = 1'b0;
    c = idx_wrap(32'(ptr), N);
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && req[c]) begin
        grant_valid = 1'b1;
        grant_idx   = M'(c);
      end
      c = idx_wrap(c, N);
    end
  end

  // Reset to N-1 so the first search after reset starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= M'(N - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// Registered, handshaked N:1 mux with fixed or round-robin selection.
// Ports: clk, rst (async, active-high), bus (slave side of mux_n_rr_if).
module mux_n_rr
  import mux_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 8,
  parameter int M = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  mux_n_rr_if.slave bus
);

  logic         load_en;
  logic         load;
  logic         fix_ok;
  logic         gv;
  logic [M-1:0] g;
  logic [M-1:0] rr_idx;
  logic         rr_valid;
  logic         advance;
  logic [W-1:0] data;

  logic         q_valid;
  logic [W-1:0] q_out;
  logic [M-1:0] q_sel;

  assign load_en = !q_valid | bus.out_ready;

  // Out-of-range selects never grant and never wrap.
  assign fix_ok = (32'(bus.select) < N) &&
                  bus.in_valid[bus.select];

  rr_arbiter_n #(
    .N (N),
    .M (M)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.in_valid),
    .advance     (advance),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  // Grant is masked during reset so in_ready drops at once.
  always_comb begin
    if (bus.mode == MODE_RR) begin
      g  = rr_idx;
      gv = rr_valid;
    end else begin
      g  = bus.select;
      gv = fix_ok;
    end
    if (rst) gv = 1'b0;
  end

  assign load    = load_en & gv;
  assign advance = load & (bus.mode == MODE_RR);

  always_comb begin
    data         = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (M'(i) == g) begin
        data            = bus.inp[i*W +: W];
        bus.in_ready[i] = load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_out   <= '0;
      q_sel   <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_out   <= data;
      q_sel   <= g;
    end else if (bus.out_ready) begin
      q_valid <= 1'b0;
    end
  end

  assign bus.out       = q_out;
  assign bus.out_valid = q_valid;
  assign bus.out_sel   = q_sel;

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed self-checking bench for mux_n_rr (N=16, W=8).
// Drives the interface master side; checks #1 after each rising edge.
module tb_mux_n_rr;

  localparam int N = 16;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   tally [N];

  mux_n_rr_if #(.N(N), .W(W)) bus ();

  mux_n_rr #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dat(input int i);
    if (i == 13) return 8'hA5;
    if (i == 5)  return 8'h3C;
    return 8'h10 + 8'(i);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < N; i++) tally[i] = 0;

    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.select    = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.inp[i*W +: W] = dat(i);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_sel", 32'(bus.out_sel), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);

    @(negedge clk);
    rst = 1'b0;

    // Fixed mode, channel 13
    bus.mode      = 1'b0;
    bus.select    = 4'd13;
    bus.in_valid  = 16'h2000;
    bus.out_ready = 1'b1;
    #1;
    chk("fix_ready13", 32'(bus.in_ready), 32'h2000);
    step();
    chk("fix_out13", 32'(bus.out), 32'hA5);
    chk("fix_sel13", 32'(bus.out_sel), 13);
    chk("fix_valid13", 32'(bus.out_valid), 1);

    // Fixed mode, select with no valid
    bus.select = 4'd9;
    #1;
    chk("fix_ready9", 32'(bus.in_ready), 0);
    step();
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_out", 32'(bus.out), 32'hA5);
    chk("drain_sel", 32'(bus.out_sel), 13);

    // Reset mid-cycle while holding a word
    bus.select = 4'd13;
    step();
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_out", 32'(bus.out), 0);
    chk("arst_sel", 32'(bus.out_sel), 0);
    chk("arst_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin, all valid, 20 transfers
    bus.mode     = 1'b1;
    bus.in_valid = 16'hFFFF;
    #1;
    chk("rr_first_ready", 32'(bus.in_ready), 32'h0001);
    for (int t = 0; t < 20; t++) begin
      step();
      exp_sel = t % 16;
      chk("rr_sel", 32'(bus.out_sel), 32'(exp_sel));
      chk("rr_out", 32'(bus.out), 32'(dat(exp_sel)));
      if (t < 16) tally[bus.out_sel]++;
    end
    for (int i = 0; i < N; i++) chk("rr_tally", tally[i], 1);

    // Sparse round-robin with wrap, fresh from reset
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 16'h8021;
    step();
    chk("sp0", 32'(bus.out_sel), 0);
    step();
    chk("sp1", 32'(bus.out_sel), 5);
    step();
    chk("sp2", 32'(bus.out_sel), 15);
    step();
    chk("sp3", 32'(bus.out_sel), 0);
    step();
    chk("sp4", 32'(bus.out_sel), 5);
    chk("sp4_out", 32'(bus.out), 32'h3C);

    // Backpressure holding 8'h3C
    bus.out_ready = 1'b0;
    bus.in_valid  = 16'hFFFF;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready), 0);
      step();
      chk("bp_out", 32'(bus.out), 32'h3C);
      chk("bp_sel", 32'(bus.out_sel), 5);
      chk("bp_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(bus.in_ready), 32'h0040);
    step();
    chk("bp_rel_sel", 32'(bus.out_sel), 6);
    chk("bp_rel_out", 32'(bus.out), 32'h16);
    chk("bp_rel_valid", 32'(bus.out_valid), 1);

    // Mode switch: RR grants 4, fixed 2 x3, back to RR
    bus.in_valid = 16'h0010;
    step();
    chk("ms_rr4", 32'(bus.out_sel), 4);
    bus.mode     = 1'b0;
    bus.select   = 4'd2;
    bus.in_valid = 16'hFFFF;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("ms_fix2", 32'(bus.out_sel), 2);
      chk("ms_fix2_out", 32'(bus.out), 32'h12);
    end
    bus.mode = 1'b1;
    #1;
    chk("ms_rr_ready", 32'(bus.in_ready), 32'h0020);
    step();
    chk("ms_rr5", 32'(bus.out_sel), 5);

    // Final drain
    bus.in_valid = '0;
    step();
    chk("end_valid", 32'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
